uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path. It accepts a parallel byte with a valid strobe and latches the data and parity configuration. It sequences the serializer through start, data, optional parity and stop phases, and drives the TX line through an internal 4:1 bit-source mux. It sits between the system-side Tx interface and the serializer, and reports Busy and a framing-consistency error.

Parameters:
WIDTH, 8, data bits per frame (4..8); sets the bit-counter range.

Ports:
CLK  input  1  transmit bit clock, one UART bit per cycle
RST  input  1  asynchronous reset, active-low
P_DATA  input  WIDTH  parallel data from system side
Data_Valid  input  1  single-cycle request strobe; sampled only when accepting
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even, 1 = odd
S_DATA  input  1  serial bit from serializer
Ser_Done  input  1  serializer completion flag
Ser_En  output  1  serializer enable
Ser_Data  output  WIDTH  latched frame data to serializer load port
TX_OUT  output  1  UART line
Busy  output  1  frame in progress
Err  output  1  one-cycle pulse: serializer/controller bit-count mismatch

Behaviour:
- Clocking and reset: CLK is the single clock. RST is asynchronous, active-low.
- Reset values: state=IDLE, Ser_En=0, Ser_Data=0, Busy=0, Err=0, TX_OUT=1, bit counter=0, latched PAR_EN/PAR_TYP/parity=0.
- States: IDLE, START, DATA, PARITY, STOP. The state is one-hot or binary, registered.
- IDLE: TX_OUT=1, Busy=0.
  - When Data_Valid=1 at a clock edge: latch P_DATA into Ser_Data, latch PAR_EN and PAR_TYP, compute parity = ^P_DATA XOR PAR_TYP, then go to START.
  - Latency: TX_OUT goes low on the first cycle after the accepting edge.
- START: exactly one cycle. TX_OUT=0, Ser_En=1 (serializer loads Ser_Data), Busy=1. Next state is DATA and the bit counter clears to 0.
- DATA: exactly WIDTH cycles. TX_OUT=S_DATA and Ser_En=1.
  - The counter increments each cycle.
  - When counter==WIDTH-1: if the latched PAR_EN=1 go to PARITY, else go to STOP.
  - Serializer contract: bit i (LSB first) is presented on S_DATA in DATA cycle i.
- PARITY: one cycle. TX_OUT=latched parity bit, Ser_En=0. Next state is STOP.
- STOP: one cycle. TX_OUT=1, Busy=1, Ser_En=0.
  - If Data_Valid=1 at the STOP edge: accept as in IDLE and go directly to START (back-to-back frames, no idle bit).
  - Otherwise go to IDLE.
- Err: Ser_Done is sampled on the first cycle after DATA (PARITY or STOP). If Ser_Done=0 there, Err pulses high for one cycle. The frame still completes normally; Err does not alter the state sequence.
- Busy is registered: high in START, DATA, PARITY and STOP; low only in IDLE.
- Data_Valid is ignored in START, DATA and PARITY. No queuing, so a dropped request is the requester's responsibility (it must watch Busy).
- P_DATA, PAR_EN and PAR_TYP changes after acceptance have no effect on the frame in flight.
- Frame length: WIDTH+2 cycles, or WIDTH+3 with parity.
- TX_OUT mux: a pure decode of the registered state and S_DATA, with no other logic.
  - Encoding: 00 start(0), 01 stop/idle(1), 10 S_DATA, 11 parity.
- Reset mid-frame: immediate return to reset values. TX_OUT=1 asynchronously; no partial stop bit is generated.

Decomposition:
- Shared uart_pkg holds:
  - state encoding constants (IDLE/START/DATA/PARITY/STOP);
  - TX mux select constants (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR);
  - PAR_EVEN/PAR_ODD.
- One natural sub-module, uart_tx_parity: combinational, P_DATA and PAR_TYP in, parity bit out. It is reused by the receive-side checker.
- The FSM, counter and mux stay in uart_tx_ctrl.

Test Plan:
- Reset with RST low for 3 cycles -> TX_OUT=1, Busy=0, Ser_En=0, Err=0; holding RST low keeps them there.
- P_DATA=0xA5, PAR_EN=0, one Data_Valid pulse, serializer model attached -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles). Busy high for exactly 10 cycles, Err=0.
- P_DATA=0xA5, PAR_EN=1: with PAR_TYP=0 the parity cycle shows TX_OUT=0; with PAR_TYP=1 it shows TX_OUT=1. Frame is 11 cycles.
- Back-to-back: 0x0F, then Data_Valid with 0xF0 asserted in the STOP cycle -> the next START follows the stop bit with no idle cycle. A Data_Valid pulse during DATA is ignored (no third frame).
- Serializer model holds Ser_Done=0 -> Err pulses exactly once, in the cycle after the last data bit, and the stop bit is still sent.
- RST asserted during DATA bit 3 -> TX_OUT=1 and Busy=0 immediately. After release, a new 0x3C frame transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared encodings for the UART transmit/receive path: frame
//            state encoding, TX line bit-source select codes and parity
//            type codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame sequencer states (binary encoded)
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // TX line bit-source select
  localparam logic [1:0] MUX_START = 2'b00;  // constant 0
  localparam logic [1:0] MUX_STOP  = 2'b01;  // constant 1 (also idle level)
  localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
  localparam logic [1:0] MUX_PAR   = 2'b11;  // latched parity bit

  // Parity type
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Purpose  : Combinational parity generator. Produces the parity bit that
//            makes the total count of ones (data + parity) even or odd.
// Ports    : P_DATA  in  [WIDTH-1:0] data word
//            PAR_TYP in  0 = even, 1 = odd
//            PAR_BIT out parity bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             PAR_TYP,
  output logic             PAR_BIT
);

  // Even parity is the XOR reduction itself; odd parity inverts it.
  assign PAR_BIT = (^P_DATA) ^ (PAR_TYP == PAR_ODD);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit frame controller. Accepts a parallel byte on a
//            valid strobe, sequences the external serializer through
//            start / data / optional parity / stop, and drives the TX line
//            through a 4:1 bit-source mux.
// Ports    : CLK        in   bit clock (one UART bit per cycle)
//            RST        in   asynchronous reset, active-low
//            P_DATA     in   [WIDTH-1:0] parallel data
//            Data_Valid in   request strobe, sampled in IDLE/STOP only
//            PAR_EN     in   1 = append parity bit
//            PAR_TYP    in   0 = even, 1 = odd
//            S_DATA     in   serial bit from serializer
//            Ser_Done   in   serializer completion flag
//            Ser_En     out  serializer enable
//            Ser_Data   out  [WIDTH-1:0] latched frame data
//            TX_OUT     out  UART line
//            Busy       out  frame in progress
//            Err        out  serializer/controller bit-count mismatch pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             S_DATA,
  input  logic             Ser_Done,
  output logic             Ser_En,
  output logic [WIDTH-1:0] Ser_Data,
  output logic             TX_OUT,
  output logic             Busy,
  output logic             Err
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  tx_state_t        r_state;
  tx_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_ser_data;
  logic             r_par_en;
  logic             r_parity;
  logic             r_busy;
  logic             r_after_data;
  logic             w_accept;
  logic             w_ser_en;
  logic             w_par_bit;
  logic [1:0]       w_sel;
  logic             w_tx;

  // Parity is computed from the inputs at acceptance and held, so later
  // changes on P_DATA/PAR_TYP cannot disturb the frame in flight.
  uart_tx_parity #(
    .WIDTH   (WIDTH)
  ) u_parity (
    .P_DATA  (P_DATA),
    .PAR_TYP (PAR_TYP),
    .PAR_BIT (w_par_bit)
  );

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state decode
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ser_en = 1'b0;
    w_sel    = MUX_STOP;
    case (r_state)
      IDLE: begin
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_next   = START;
        end
      end
      START: begin
        w_sel    = MUX_START;
        w_ser_en = 1'b1;
        w_next   = DATA;
      end
      DATA: begin
        w_sel    = MUX_DATA;
        w_ser_en = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_next = r_par_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        w_sel  = MUX_PAR;
        w_next = STOP;
      end
      STOP: begin
        // Back-to-back frames: a request in the stop cycle goes straight
        // to START with no idle bit in between.
        if (Data_Valid) begin
          w_accept = 1'b1;
          w_next   = START;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Frame data, bit counter and status registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ser_data   <= '0;
      r_par_en     <= 1'b0;
      r_parity     <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_after_data <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ser_data <= P_DATA;
        r_par_en   <= PAR_EN;
        r_parity   <= w_par_bit;
      end
      if (r_state == START) begin
        r_cnt <= '0;
      end else if (r_state == DATA) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_busy       <= (w_next != IDLE);
      // Marks the single cycle following the last data bit, where the
      // serializer must report completion.
      r_after_data <= (r_state == DATA) && (w_next != DATA);
    end
  end

  // TX line bit-source mux
  always_comb begin
    w_tx = 1'b1;
    case (w_sel)
      MUX_START: w_tx = 1'b0;
      MUX_STOP:  w_tx = 1'b1;
      MUX_DATA:  w_tx = S_DATA;
      MUX_PAR:   w_tx = r_parity;
      default:   w_tx = 1'b1;
    endcase
  end

  assign TX_OUT   = w_tx;
  assign Ser_En   = w_ser_en;
  assign Ser_Data = r_ser_data;
  assign Busy     = r_busy;
  assign Err      = r_after_data & ~Ser_Done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl with a serializer model
//            and a per-cycle scoreboard of expected line/enable/error values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int WIDTH = 8;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             S_DATA;
  logic             Ser_Done;
  logic             Ser_En;
  logic [WIDTH-1:0] Ser_Data;
  logic             TX_OUT;
  logic             Busy;
  logic             Err;

  uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .S_DATA     (S_DATA),
    .Ser_Done   (Ser_Done),
    .Ser_En     (Ser_En),
    .Ser_Data   (Ser_Data),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy),
    .Err        (Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Serializer model: loads on the first enabled cycle (START), then shifts
  // once per enabled cycle, presenting bit i in DATA cycle i.
  logic [WIDTH-1:0] sh;
  int               scnt;
  logic             en_d;
  logic             hold_done_low;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sh   <= '0;
      scnt <= 0;
      en_d <= 1'b0;
    end else begin
      en_d <= Ser_En;
      if (Ser_En && !en_d) begin
        sh   <= Ser_Data;
        scnt <= 0;
      end else if (Ser_En) begin
        sh   <= sh >> 1;
        scnt <= scnt + 1;
      end
    end
  end

  assign S_DATA   = sh[0];
  assign Ser_Done = (scnt == WIDTH) && !hold_done_low;

  // Scoreboard
  typedef struct {
    logic tx;
    logic en;
    logic err;
    int   fr;
    int   pos;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   fr_id;
  logic mon_en;

  task automatic chk(input string name, input int fr, input int pos,
                     input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s frame=%0d pos=%0d actual=%b required=%b",
               name, fr, pos, act, req);
    end
  endtask

  // Monitor: each cycle either an expected frame bit is due (Busy high) or
  // the line must be idle.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        exp_t it;
        it = q.pop_front();
        chk("busy",   it.fr, it.pos, Busy,   1'b1);
        chk("tx",     it.fr, it.pos, TX_OUT, it.tx);
        chk("ser_en", it.fr, it.pos, Ser_En, it.en);
        chk("err",    it.fr, it.pos, Err,    it.err);
      end else begin
        chk("idle_busy", -1, 0, Busy,   1'b0);
        chk("idle_tx",   -1, 0, TX_OUT, 1'b1);
        chk("idle_en",   -1, 0, Ser_En, 1'b0);
        chk("idle_err",  -1, 0, Err,    1'b0);
      end
    end
  end

  // Push the expected per-cycle line values of one frame. par_bit is the
  // hand-computed parity; done_ok=0 expects Err in the cycle after data.
  task automatic push_frame(input logic [WIDTH-1:0] d, input logic pe,
                            input logic par_bit, input logic done_ok);
    int p;
    p = 0;
    q.push_back('{tx: 1'b0, en: 1'b1, err: 1'b0, fr: fr_id, pos: p++});
    for (int i = 0; i < WIDTH; i++)
      q.push_back('{tx: d[i], en: 1'b1, err: 1'b0, fr: fr_id, pos: p++});
    if (pe) begin
      q.push_back('{tx: par_bit, en: 1'b0, err: !done_ok, fr: fr_id, pos: p++});
      q.push_back('{tx: 1'b1, en: 1'b0, err: 1'b0, fr: fr_id, pos: p++});
    end else begin
      q.push_back('{tx: 1'b1, en: 1'b0, err: !done_ok, fr: fr_id, pos: p++});
    end
    fr_id++;
  endtask

  // Issue one request; called #1 after a clock edge. Expectations are pushed
  // at the accepting edge, then the inputs are scrambled.
  task automatic send(input logic [WIDTH-1:0] d, input logic pe,
                      input logic pt, input logic par_bit, input logic done_ok);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    push_frame(d, pe, par_bit, done_ok);
    #1;
    Data_Valid = 1'b0;
    P_DATA     = ~d;
    PAR_EN     = ~pe;
    PAR_TYP    = ~pt;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      @(posedge CLK);
      #1;
      if (q.size() == 0 && !Busy) break;
    end
    if (k == 60) chk("wait_idle_timeout", -1, 0, 1'b1, 1'b0);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    fr_id         = 0;
    mon_en        = 1'b0;
    hold_done_low = 1'b0;
    RST           = 1'b0;
    Data_Valid    = 1'b0;
    P_DATA        = '0;
    PAR_EN        = 1'b0;
    PAR_TYP       = 1'b0;

    // Reset held for 3 cycles
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx",   -1, 0, TX_OUT, 1'b1);
    chk("rst_busy", -1, 0, Busy,   1'b0);
    chk("rst_en",   -1, 0, Ser_En, 1'b0);
    chk("rst_err",  -1, 0, Err,    1'b0);
    // A request while still in reset has no effect
    P_DATA     = 8'hA5;
    Data_Valid = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    chk("rst_hold_tx",   -1, 0, TX_OUT, 1'b1);
    chk("rst_hold_busy", -1, 0, Busy,   1'b0);
    chk("rst_hold_en",   -1, 0, Ser_En, 1'b0);
    chk("rst_hold_data", -1, 0, (Ser_Data == 8'h00), 1'b1);
    RST    = 1'b1;
    mon_en = 1'b1;
    @(posedge CLK);
    #1;

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    // 0xA5 with even parity (four ones) -> parity 0
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    // 0xA5 with odd parity -> parity 1
    send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // Back-to-back: second request raised during the stop cycle of the first
    send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (9) @(posedge CLK);
    #1;
    send(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Request during DATA must be ignored
    repeat (3) @(posedge CLK);
    #1;
    P_DATA     = 8'h55;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    wait_idle();

    // Serializer never reports done -> single Err pulse on the stop cycle
    hold_done_low = 1'b1;
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();
    hold_done_low = 1'b0;

    // Reset during DATA bit 3 (line would be 0 there)
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge CLK);
    #2;
    RST = 1'b0;
    q.delete();
    #1;
    chk("midrst_tx",   -1, 0, TX_OUT, 1'b1);
    chk("midrst_busy", -1, 0, Busy,   1'b0);
    chk("midrst_en",   -1, 0, Ser_En, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle();
    repeat (3) @(posedge CLK);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
